// File: rtl/seriallite3_tx_burst_framer_if.sv
// Packet-stream input and SerialLite III TX framing bundle for the burst framer.
interface seriallite3_tx_burst_framer_if #(
  parameter int unsigned LANES = 4
);
  localparam int unsigned DATA_W = 64 * LANES;

  logic [DATA_W-1:0] in_data;
  logic [7:0]        in_sync;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] data_tx;
  logic              valid_tx;
  logic              ready_tx;
  logic              start_of_burst_tx;
  logic              end_of_burst_tx;
  logic [7:0]        sync_tx;

  // Packet source / core side
  modport master (
    output in_data, in_sync, in_last, in_valid, ready_tx,
    input  in_ready, data_tx, valid_tx, start_of_burst_tx, end_of_burst_tx, sync_tx
  );

  // Framer side
  modport slave (
    input  in_data, in_sync, in_last, in_valid, ready_tx,
    output in_ready, data_tx, valid_tx, start_of_burst_tx, end_of_burst_tx, sync_tx
  );
endinterface

// File: rtl/seriallite3_tx_burst_framer.sv
// Buffers a packet stream and cuts it into gap-free bursts of at most MAX_BURST
// words for the SerialLite III TX core; flushes the rest of a packet on link loss.
module seriallite3_tx_burst_framer #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MAX_BURST = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     user_clock_tx,
  input  logic                     user_clock_reset_tx_n,
  seriallite3_tx_burst_framer_if.slave bus,
  input  logic                     link_up_tx,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         bursts_sent,
  output logic [CNT_W-1:0]         words_dropped
);

  localparam int unsigned DATA_W = 64 * LANES;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned BW     = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [7:0]        mem_sync_q [DEPTH];
  logic              mem_last_q [DEPTH];
  logic [LW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     pkt_q, pkt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [7:0]        sync_q, sync_d;
  logic [CNT_W-1:0]  bursts_q, bursts_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;

  logic [LW-1:0]     level_c;
  logic              push_c, pop_c, empty_c;
  logic              valid_c, sob_c, eob_c;
  logic [DATA_W-1:0] head_data_c;
  logic [7:0]        head_sync_c;
  logic              head_last_c;

  assign level_c     = wr_ptr_q - rd_ptr_q;
  assign empty_c     = (level_c == '0);
  assign push_c      = bus.in_valid & bus.in_ready;
  assign head_data_c = mem_data_q[rd_ptr_q[AW-1:0]];
  assign head_sync_c = mem_sync_q[rd_ptr_q[AW-1:0]];
  assign head_last_c = mem_last_q[rd_ptr_q[AW-1:0]];

  // FIFO storage; no reset needed, occupancy lives in the pointers
  always_ff @(posedge user_clock_tx) begin
    if (push_c) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
      mem_sync_q[wr_ptr_q[AW-1:0]] <= bus.in_sync;
      mem_last_q[wr_ptr_q[AW-1:0]] <= bus.in_last;
    end
  end

  // Count of complete packet ends sitting in the FIFO
  always_comb begin
    pkt_d = pkt_q;
    if (push_c && bus.in_last) pkt_d = pkt_d + LW'(1);
    if (pop_c && head_last_c)  pkt_d = pkt_d - LW'(1);
  end

  // Burst FSM: next state, pop and framing outputs
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    sync_d    = sync_q;
    bursts_d  = bursts_q;
    dropped_d = dropped_q;
    pop_c     = 1'b0;
    valid_c   = 1'b0;
    sob_c     = 1'b0;
    eob_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a full burst or a whole packet tail must already be buffered
        if (link_up_tx && (level_c >= LW'(MAX_BURST) || pkt_q != '0)) begin
          state_d = S_BURST;
          sync_d  = head_sync_c;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (!link_up_tx) begin
          state_d = S_FLUSH;
        end else begin
          valid_c = 1'b1;
          sob_c   = (beat_q == '0);
          eob_c   = head_last_c || (beat_q == BW'(MAX_BURST - 1));
          if (bus.ready_tx) begin
            pop_c  = 1'b1;
            beat_d = beat_q + BW'(1);
            if (eob_c) begin
              state_d = S_IDLE;
              if (bursts_q != {CNT_W{1'b1}}) bursts_d = bursts_q + CNT_W'(1);
            end
          end
        end
      end
      S_FLUSH: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          if (dropped_q != {CNT_W{1'b1}}) dropped_d = dropped_q + CNT_W'(1);
          if (head_last_c) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointers and counters
  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_q     <= '0;
      beat_q    <= '0;
      sync_q    <= '0;
      bursts_q  <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      beat_q    <= beat_d;
      sync_q    <= sync_d;
      bursts_q  <= bursts_d;
      dropped_q <= dropped_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  assign bus.in_ready          = (level_c != LW'(DEPTH));
  assign bus.valid_tx          = valid_c;
  assign bus.start_of_burst_tx = sob_c;
  assign bus.end_of_burst_tx   = eob_c;
  assign bus.sync_tx           = sync_q;
  assign bus.data_tx           = (state_q == S_BURST) ? head_data_c : '0;
  assign fifo_level            = level_c;
  assign bursts_sent           = bursts_q;
  assign words_dropped         = dropped_q;

endmodule

// File: tb/tb_seriallite3_tx_burst_framer.sv
// Directed + randomized bench for the burst framer; expected beats are derived
// from the per-packet burst-splitting rule, independent of the FIFO/FSM.
module tb_seriallite3_tx_burst_framer;
  localparam int unsigned LANES     = 4;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned MAX_BURST = 32;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned DATA_W    = 64 * LANES;
  localparam int unsigned LW        = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [7:0]        sync;
    logic              sob;
    logic              eob;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_up = 1'b0;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] bursts_sent, words_dropped;

  seriallite3_tx_burst_framer_if #(.LANES(LANES)) bus ();

  seriallite3_tx_burst_framer #(
    .LANES(LANES), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .user_clock_tx        (clk),
    .user_clock_reset_tx_n(rst_n),
    .bus                  (bus),
    .link_up_tx           (link_up),
    .fifo_level           (fifo_level),
    .bursts_sent          (bursts_sent),
    .words_dropped        (words_dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  beat_t exp_q[$];
  int beats_seen = 0;
  int exp_bursts = 0;
  int exp_dropped = 0;
  int ready_mode = 0;
  logic [DATA_W-1:0] pk_data[$];
  logic [7:0]        pk_sync[$];

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flag(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: got no event expected event within bound", tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < int'(DATA_W / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Build a packet and the beats it must produce: chunks of MAX_BURST from packet start
  task automatic gen_pkt(input int len);
    beat_t b;
    int cs;
    pk_data.delete();
    pk_sync.delete();
    for (int i = 0; i < len; i++) begin
      pk_data.push_back(rnd_word());
      pk_sync.push_back(8'($urandom));
      cs     = (i / int'(MAX_BURST)) * int'(MAX_BURST);
      b.data = pk_data[i];
      b.sync = pk_sync[cs];
      b.sob  = (i % int'(MAX_BURST) == 0);
      b.eob  = (i == len - 1) || (i % int'(MAX_BURST) == int'(MAX_BURST) - 1);
      exp_q.push_back(b);
    end
    exp_bursts += (len + int'(MAX_BURST) - 1) / int'(MAX_BURST);
  endtask

  // Offer one word and hold it until accepted; entered and left at posedge+1
  task automatic push_word(input logic [DATA_W-1:0] d, input logic [7:0] s,
                           input logic l, input bit gappy);
    int n;
    bit acc;
    if (gappy && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = d;
    bus.in_sync  = s;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 3000) begin
        flag("push_timeout");
        break;
      end
    end
  endtask

  task automatic send_pkt(input int len, input bit gappy);
    gen_pkt(len);
    for (int i = 0; i < len; i++) push_word(pk_data[i], pk_sync[i], (i == len - 1), gappy);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) flag("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (beats_seen < target) flag("beat_wait_timeout");
  endtask

  // Ready pattern generator for the core side
  initial begin
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int ph = 0;
    bus.ready_tx = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ready_tx = 1'b1;
        1:       bus.ready_tx = 1'($urandom_range(0, 1));
        default: begin bus.ready_tx = pat[ph % 6]; ph++; end
      endcase
    end
  end

  // Beat monitor: ordering vs the model, stall stability, no gaps inside a burst
  beat_t prev;
  logic  prev_v = 1'b0, prev_r = 1'b0, prev_link = 1'b0, prev_ok = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur.data = bus.data_tx;
    cur.sync = bus.sync_tx;
    cur.sob  = bus.start_of_burst_tx;
    cur.eob  = bus.end_of_burst_tx;
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && link_up && prev_link) begin
        if (prev_v && !prev_r)
          chk("stall_hold", 300'({bus.valid_tx, cur}), 300'({1'b1, prev}));
        else if (prev_v && prev_r && !prev.eob)
          chk("burst_gap", 300'(bus.valid_tx), 300'(1));
      end
      if (bus.valid_tx && bus.ready_tx) begin
        beats_seen++;
        if (exp_q.size() == 0) flag("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          chk("beat", 300'(cur), 300'(e));
        end
      end
      prev      = cur;
      prev_v    = bus.valid_tx;
      prev_r    = bus.ready_tx;
      prev_link = link_up;
      prev_ok   = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bus.in_data  = '0;
    bus.in_sync  = '0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset values
    chk("rst_in_ready", 300'(bus.in_ready), 300'(1));
    chk("rst_valid", 300'({bus.valid_tx, bus.start_of_burst_tx, bus.end_of_burst_tx}), 300'(0));
    chk("rst_sync_data", 300'({bus.sync_tx, bus.data_tx}), 300'(0));
    chk("rst_level", 300'(fifo_level), 300'(0));
    chk("rst_counters", 300'({bursts_sent, words_dropped}), 300'(0));
    rst_n   = 1'b1;
    link_up = 1'b1;
    @(posedge clk); #1;

    // T1: short packet
    send_pkt(3, 1'b0);
    wait_drain();
    chk("t1_bursts", 300'(bursts_sent), 300'(1));
    chk("t1_level", 300'(fifo_level), 300'(0));

    // T2: packet split into 32 + 8
    send_pkt(40, 1'b0);
    wait_drain();
    chk("t2_bursts", 300'(bursts_sent), 300'(3));

    // T3: stalling core during a 10-word burst
    ready_mode = 2;
    base = beats_seen;
    send_pkt(10, 1'b0);
    wait_drain();
    ready_mode = 0;
    chk("t3_beats", 300'(beats_seen - base), 300'(10));
    chk("t3_bursts", 300'(bursts_sent), 300'(4));

    // T4: link loss after 5 beats of a 20-word packet
    base = beats_seen;
    send_pkt(20, 1'b0);
    wait_beats(base + 5);
    link_up = 1'b0;
    #1;
    chk("t4_valid_drop", 300'(bus.valid_tx), 300'(0));
    repeat (25) @(posedge clk);
    #1;
    chk("t4_beats", 300'(beats_seen - base), 300'(5));
    chk("t4_dropped", 300'(words_dropped), 300'(15));
    chk("t4_level", 300'(fifo_level), 300'(0));
    chk("t4_bursts", 300'(bursts_sent), 300'(4));
    exp_q.delete();
    exp_bursts  -= 1;
    exp_dropped += 15;
    link_up = 1'b1;
    send_pkt(5, 1'b0);
    wait_drain();
    chk("t4_next_bursts", 300'(bursts_sent), 300'(5));

    // T5: fill with link down, backpressure at DEPTH, then drain
    link_up = 1'b0;
    gen_pkt(70);
    for (int i = 0; i < int'(DEPTH); i++) push_word(pk_data[i], pk_sync[i], 1'b0, 1'b0);
    bus.in_data  = pk_data[DEPTH];
    bus.in_sync  = pk_sync[DEPTH];
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_in_ready", 300'(bus.in_ready), 300'(0));
    chk("t5_level", 300'(fifo_level), 300'(DEPTH));
    link_up = 1'b1;
    for (int i = int'(DEPTH); i < 70; i++) push_word(pk_data[i], pk_sync[i], (i == 69), 1'b0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_drain();
    chk("t5_bursts", 300'(bursts_sent), 300'(8));

    // Randomized packets with random core backpressure and input gaps
    ready_mode = 1;
    for (int k = 0; k < 8; k++) send_pkt(int'($urandom_range(1, 70)), 1'b1);
    wait_drain();
    ready_mode = 0;
    chk("rand_bursts", 300'(bursts_sent), 300'(exp_bursts));
    chk("rand_dropped", 300'(words_dropped), 300'(exp_dropped));
    chk("rand_level", 300'(fifo_level), 300'(0));

    // T6: asynchronous reset in the middle of a burst
    base = beats_seen;
    send_pkt(20, 1'b0);
    wait_beats(base + 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_framing", 300'({bus.valid_tx, bus.start_of_burst_tx, bus.end_of_burst_tx}), 300'(0));
    chk("t6_level", 300'(fifo_level), 300'(0));
    chk("t6_counters", 300'({bursts_sent, words_dropped}), 300'(0));
    chk("t6_in_ready", 300'(bus.in_ready), 300'(1));
    exp_q.delete();
    exp_bursts  = 0;
    exp_dropped = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(4, 1'b0);
    wait_drain();
    chk("t6_after_bursts", 300'(bursts_sent), 300'(1));
    chk("t6_after_level", 300'(fifo_level), 300'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
